// File: rtl/lpad_ctrl.sv
// Forward-edge CFI landing-pad controller: arms on indirect jumps, checks the next
// accepted decode entry for a matching LPAD, and raises a software-check fault otherwise.
//
// state  | meaning
// IDLE   | no landing pad expected
// EXPECT | next accepted entry must be an LPAD matching label_q (or wildcard)
// FAULT  | check failed; fault pending, decode stalled until ex_ack_i
module lpad_ctrl #(
  parameter int LABEL_W = 20,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               debug_mode_i,
  input  logic               trap_i,
  input  logic               jump_valid_i,
  input  logic [LABEL_W-1:0] jump_label_i,
  input  logic               instr_valid_i,
  input  logic               instr_ready_i,
  input  logic [31:0]        instr_i,
  input  logic               is_compressed_i,
  output logic               elp_o,
  output logic               stall_o,
  output logic               ex_valid_o,
  output logic [LABEL_W-1:0] ex_tval_o,
  input  logic               ex_ack_i,
  output logic [CNT_W-1:0]   viol_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPECT = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t             state_q;
  logic [LABEL_W-1:0] label_q;
  logic [LABEL_W-1:0] tval_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               elp_q;
  logic               fault_q;

  logic               handshake;
  logic               is_lpad;
  logic               label_match;
  logic               check_pass;
  logic               cnt_full;

  // The check is combinational on the handshake but only ever lands in flops.
  always_comb begin
    handshake   = instr_valid_i & instr_ready_i;
    is_lpad     = (instr_i[6:0] == 7'b0010111) && (instr_i[11:7] == 5'd0) && !is_compressed_i;
    label_match = (instr_i[31:12] == '0) || (instr_i[31:12] == label_q);
    check_pass  = is_lpad && label_match;
    cnt_full    = &cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      label_q <= '0;
      tval_q  <= '0;
      cnt_q   <= '0;
      elp_q   <= 1'b0;
      fault_q <= 1'b0;
    end else if (trap_i || !en_i || debug_mode_i) begin
      state_q <= IDLE;
      elp_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (jump_valid_i) begin
            state_q <= EXPECT;
            label_q <= jump_label_i;
            elp_q   <= 1'b1;
          end
        end
        EXPECT: begin
          if (handshake && !check_pass) begin
            state_q <= FAULT;
            tval_q  <= label_q;
            elp_q   <= 1'b0;
            fault_q <= 1'b1;
            if (!cnt_full) cnt_q <= cnt_q + 1'b1;
          end else if (handshake) begin
            if (jump_valid_i) begin
              label_q <= jump_label_i;
            end else begin
              state_q <= IDLE;
              elp_q   <= 1'b0;
            end
          end else if (jump_valid_i) begin
            label_q <= jump_label_i;
          end
        end
        FAULT: begin
          // Jumps are ignored here; the fault must be taken first.
          if (ex_ack_i) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          elp_q   <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign elp_o      = elp_q;
  assign stall_o    = fault_q;
  assign ex_valid_o = fault_q;
  assign ex_tval_o  = tval_q;
  assign viol_cnt_o = cnt_q;

endmodule

// File: doc/lpad_ctrl.md
# lpad_ctrl

Forward-edge CFI landing-pad controller that sequences the decode stage's expected-landing-pad (ELP) state. It arms on every resolved indirect jump and latches the jump's label. The next instruction accepted by decode must be a matching LPAD, otherwise the block raises a software-check fault and stalls decode until the fault is taken. It drives the decoder's `xLPAD_i` and sits beside the ID stage, fed by the branch unit (jump events) and the CSR file (enable, trap).

## Interface
Parameters:
- LABEL_W, 20, label width; equals LPAD immediate width `instr[31:12]`.
- CNT_W, 16, width of the saturating violation counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  landing-pad enforcement enable for the current privilege level (CSR).
- debug_mode_i  in  1  core in debug mode; checks suppressed.
- trap_i  in  1  exception/interrupt taken this cycle.
- jump_valid_i  in  1  indirect jump (JALR, non-return) resolved this cycle.
- jump_label_i  in  LABEL_W  expected label (x7[31:12]) for that jump.
- instr_valid_i  in  1  decode has a fetch entry.
- instr_ready_i  in  1  decode accepts the entry this cycle (handshake = valid & ready).
- instr_i  in  32  expanded instruction.
- is_compressed_i  in  1  entry was compressed.
- elp_o  out  1  ELP state to the decoder (`xLPAD_i`).
- stall_o  out  1  blocks decode acceptance while a fault is pending.
- ex_valid_o  out  1  software-check fault pending.
- ex_tval_o  out  LABEL_W  expected label of the faulting check.
- ex_ack_i  in  1  fault consumed by the commit/CSR path.
- viol_cnt_o  out  CNT_W  saturating count of faults.

## Operation
- State machine: IDLE, EXPECT, FAULT. The state, label register, tval and counter are all flops.
- An instruction is an LPAD when `instr_i[6:0]==7'b0010111`, `instr_i[11:7]==0`, and `is_compressed_i==0`. A compressed entry is never an LPAD.
- Check passes when the entry is an LPAD and either `instr_i[31:12]==0` (wildcard) or `instr_i[31:12]==label_q`.
- Next-state priority, highest first:
  1. trap_i → IDLE.
  2. `!en_i || debug_mode_i` → IDLE.
  3. Per-state rules below.
- IDLE: jump_valid_i → EXPECT and label_q←jump_label_i. Handshakes are ignored.
- EXPECT:
  - A handshake with a failing check → FAULT. tval←label_q. Counter increments unless it is all-ones.
  - A handshake with a passing check → IDLE, unless jump_valid_i is also high in that cycle, in which case → EXPECT with the new label.
  - No handshake and jump_valid_i → stay EXPECT and relabel.
  - Handshakes that occur before the jump's flush reaches decode are still checked; the branch unit asserts jump_valid_i in the same cycle as its flush.
- FAULT:
  - Hold ex_valid_o and stall_o.
  - ex_ack_i → IDLE.
  - jump_valid_i is ignored.
- Decode flush does not change the state. A refetched target must still land on an LPAD.
- Outputs: elp_o=(state==EXPECT), stall_o=ex_valid_o=(state==FAULT), ex_tval_o=tval_q, viol_cnt_o=cnt_q.

## Timing
- Reset: state IDLE, label_q=0, tval_q=0, cnt_q=0. So elp_o=0, stall_o=0, ex_valid_o=0, ex_tval_o=0, viol_cnt_o=0.
- Reset is honoured mid-operation in any state, including FAULT with a pending fault. The pending fault is discarded.
- jump_valid_i at cycle N → elp_o=1 from cycle N+1.
- The check is combinational on the handshake cycle, using label_q.
  - Failing handshake at cycle N → ex_valid_o/stall_o=1 and viol_cnt_o incremented from N+1.
  - Passing handshake at cycle N → elp_o=0 from N+1.
- The failing instruction itself is accepted by decode. The decoder marks it illegal via xLPAD_i=1 on that same cycle. stall_o only blocks later entries.
- ex_ack_i at cycle M → ex_valid_o=0 at M+1. ex_ack_i outside FAULT has no effect.
- trap_i dominates a simultaneous failing handshake: state goes IDLE and the counter is not incremented.
- Counter saturates at 2^CNT_W−1 and never wraps.
- No combinational path from any input to any output.

## Test plan
- Reset, en_i=1, idle → all outputs 0. Handshakes of arbitrary instructions with no jump → no fault.
- jump_valid_i with label 0x12345, then handshake of LPAD 0x12345 (instr 0x12345017) → elp_o 1 for one cycle window, returns to 0, viol_cnt_o=0.
- Label 0xABCDE, then handshake of ADDI (0x00000013) → ex_valid_o=1 and stall_o=1 next cycle, ex_tval_o=0xABCDE, viol_cnt_o=1. ex_ack_i → IDLE the following cycle.
- Wildcard and compressed cases:
  - Label 0x00001, then LPAD label 0 (0x00000017) → passes.
  - Compressed entry with the same bits → fault.
- Same-cycle events:
  - Passing handshake plus jump_valid_i(label 0x2) → stays EXPECT with label 0x2.
  - trap_i plus failing handshake → IDLE, no fault.
  - en_i=0 during EXPECT → IDLE.
- CNT_W=2, force 5 faults → viol_cnt_o saturates at 3.
- Assert rst_ni low while in FAULT → all outputs 0 immediately.
